// File: rtl/sram_stream_bridge.sv
// rtl/sram_stream_bridge.sv - byte-stream to single-port sync SRAM bridge with burst support
//
// Decodes a command from the rx byte stream and runs 1..16 word bursts
// against an OpenRAM-style synchronous SRAM, auto-incrementing the address.
//   header byte : bit7 = 1 read / 0 write, bits3:0 = burst length-1, bits6:4 ignored
//   address     : ADDR_BYTES bytes, MSB first, bits above ADDR_W discarded
//   write data  : BYTES bytes per word, LSB byte first
//   read data   : BYTES bytes per word returned on tx, LSB byte first
//
// Parameters: DATA_W (word width, multiple of 8), ADDR_W (SRAM address width)
// Optional feature macro: SRAM_BRIDGE_ACK_EN - when defined, a finished write
//   burst answers with one tx byte {4'hA, len-1}; when undefined, writes are silent.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   rx_data/valid/ready   incoming byte handshake
//   tx_data/valid/ready   outgoing byte handshake
//   csb_n, we_n           SRAM chip select / write enable, both active-low
//   sram_addr, sram_din   SRAM address and write data
//   sram_dout             SRAM read data, valid one cycle after the read access
//   busy                  high whenever a command is in progress
module sram_stream_bridge #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              csb_n,
   output logic              we_n,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_din,
   input  logic [DATA_W-1:0] sram_dout,
   output logic              busy
);

   localparam int BYTES      = DATA_W / 8;
   localparam int ADDR_BYTES = (ADDR_W + 7) / 8;
   localparam logic [7:0] BYTES_M1      = 8'(BYTES - 1);
   localparam logic [7:0] ADDR_BYTES_M1 = 8'(ADDR_BYTES - 1);

   typedef enum logic [2:0] {
      S_HDR,
      S_ADDR,
      S_WR_DATA,
      S_WR_MEM,
      S_RD_MEM,
      S_RD_CAP,
      S_RD_SEND,
      S_ACK
   } state_t;

   state_t                  state;
   logic                    rw;
   logic [3:0]              cnt;
   logic [7:0]              idx;
   logic [ADDR_BYTES*8-1:0] addr_sh;
   logic [DATA_W-1:0]       word_buf;
`ifdef SRAM_BRIDGE_ACK_EN
   logic [3:0]              len_m1;
`endif

   logic                    rx_fire;
   logic                    tx_fire;
   logic [ADDR_BYTES*8-1:0] addr_next;
   logic [DATA_W-1:0]       wr_next;
   logic [DATA_W-1:0]       rd_next;

   assign rx_fire = rx_valid & rx_ready;
   assign tx_fire = tx_valid & tx_ready;

   // Address bytes arrive MSB first, so shift left; write bytes arrive LSB
   // first, so shift right and insert at the top; read bytes leave from the
   // bottom of the buffer.
   always_comb begin
      addr_next = addr_sh << 8;
      addr_next[7:0] = rx_data;
      wr_next = word_buf >> 8;
      wr_next[DATA_W-1 -: 8] = rx_data;
      rd_next = word_buf >> 8;
   end

   // Outputs are registered, so each transition sets the values the
   // destination state must present. csb_n/we_n default to idle every cycle,
   // which limits any SRAM access to exactly one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_HDR;
         rx_ready  <= 1'b0;
         tx_valid  <= 1'b0;
         tx_data   <= 8'h00;
         csb_n     <= 1'b1;
         we_n      <= 1'b1;
         sram_addr <= '0;
         sram_din  <= '0;
         busy      <= 1'b0;
         rw        <= 1'b0;
         cnt       <= 4'd0;
         idx       <= 8'd0;
         addr_sh   <= '0;
         word_buf  <= '0;
`ifdef SRAM_BRIDGE_ACK_EN
         len_m1    <= 4'd0;
`endif
      end else begin
         csb_n <= 1'b1;
         we_n  <= 1'b1;
         case (state)
            S_HDR: begin
               rx_ready <= 1'b1;
               if (rx_fire) begin
                  rw    <= rx_data[7];
                  cnt   <= rx_data[3:0];
`ifdef SRAM_BRIDGE_ACK_EN
                  len_m1 <= rx_data[3:0];
`endif
                  idx   <= 8'd0;
                  busy  <= 1'b1;
                  state <= S_ADDR;
               end
            end

            S_ADDR: begin
               if (rx_fire) begin
                  addr_sh <= addr_next;
                  if (idx == ADDR_BYTES_M1) begin
                     sram_addr <= addr_next[ADDR_W-1:0];
                     idx       <= 8'd0;
                     if (rw) begin
                        rx_ready <= 1'b0;
                        csb_n    <= 1'b0;
                        state    <= S_RD_MEM;
                     end else begin
                        state <= S_WR_DATA;
                     end
                  end else begin
                     idx <= idx + 8'd1;
                  end
               end
            end

            S_WR_DATA: begin
               if (rx_fire) begin
                  word_buf <= wr_next;
                  if (idx == BYTES_M1) begin
                     // Only a complete word ever reaches the SRAM.
                     idx      <= 8'd0;
                     rx_ready <= 1'b0;
                     csb_n    <= 1'b0;
                     we_n     <= 1'b0;
                     sram_din <= wr_next;
                     state    <= S_WR_MEM;
                  end else begin
                     idx <= idx + 8'd1;
                  end
               end
            end

            S_WR_MEM: begin
               sram_addr <= sram_addr + 1'b1;
               if (cnt == 4'd0) begin
`ifdef SRAM_BRIDGE_ACK_EN
                  tx_valid <= 1'b1;
                  tx_data  <= {4'hA, len_m1};
                  state    <= S_ACK;
`else
                  rx_ready <= 1'b1;
                  busy     <= 1'b0;
                  state    <= S_HDR;
`endif
               end else begin
                  cnt      <= cnt - 4'd1;
                  rx_ready <= 1'b1;
                  state    <= S_WR_DATA;
               end
            end

            S_RD_MEM: begin
               state <= S_RD_CAP;
            end

            S_RD_CAP: begin
               word_buf <= sram_dout;
               tx_data  <= sram_dout[7:0];
               tx_valid <= 1'b1;
               idx      <= 8'd0;
               state    <= S_RD_SEND;
            end

            S_RD_SEND: begin
               if (tx_fire) begin
                  if (idx == BYTES_M1) begin
                     tx_valid  <= 1'b0;
                     idx       <= 8'd0;
                     sram_addr <= sram_addr + 1'b1;
                     if (cnt == 4'd0) begin
                        rx_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_HDR;
                     end else begin
                        cnt   <= cnt - 4'd1;
                        csb_n <= 1'b0;
                        state <= S_RD_MEM;
                     end
                  end else begin
                     idx      <= idx + 8'd1;
                     word_buf <= rd_next;
                     tx_data  <= rd_next[7:0];
                  end
               end
            end

            S_ACK: begin
               if (tx_fire) begin
                  tx_valid <= 1'b0;
                  rx_ready <= 1'b1;
                  busy     <= 1'b0;
                  state    <= S_HDR;
               end
            end

            default: begin
               rx_ready <= 1'b0;
               tx_valid <= 1'b0;
               busy     <= 1'b0;
               state    <= S_HDR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_stream_bridge.sv
// tb/tb_sram_stream_bridge.sv - self-checking bench for sram_stream_bridge (DATA_W=32, ADDR_W=5)
module tb_sram_stream_bridge;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b1;
   logic        csb_n;
   logic        we_n;
   logic [4:0]  sram_addr;
   logic [31:0] sram_din;
   logic [31:0] sram_dout;
   logic        busy;

   sram_stream_bridge #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .csb_n(csb_n), .we_n(we_n), .sram_addr(sram_addr),
      .sram_din(sram_din), .sram_dout(sram_dout), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [31:0] init_word(input int i);
      return {8'(i + 8'hC0), 8'(i + 8'h80), 8'(i + 8'h40), 8'(i)};
   endfunction

   // SRAM macro: synchronous, read data valid the cycle after the access
   logic [31:0] sram_mem [32];
   logic [31:0] dout_r = 32'h0;
   assign sram_dout = dout_r;
   initial for (int i = 0; i < 32; i++) sram_mem[i] = init_word(i);
   always @(posedge clk) begin
      if (!csb_n) begin
         if (!we_n) sram_mem[sram_addr] <= sram_din;
         else dout_r <= sram_mem[sram_addr];
      end
   end

   // Reference model: memory image plus expected SRAM accesses and tx bytes
   logic [31:0] ref_mem [32];
   initial for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);
   logic [36:0] exp_wr [$];
   logic [4:0]  exp_rd [$];
   logic [7:0]  exp_tx [$];
   logic [31:0] words [$];

   // Observation logs for literal pins
   logic [4:0]  wr_addr_log [$];
   logic [31:0] wr_data_log [$];
   logic [7:0]  tx_log [$];
   int          wr_cnt = 0;
   int          rd_cnt = 0;
   int          tx_cnt = 0;
   logic        hold_prev = 1'b0;
   logic [7:0]  hold_data = 8'h00;

   always @(negedge clk) begin
      if (!rst_n) begin
         hold_prev = 1'b0;
      end else begin
         if (hold_prev) begin
            chk("tx_hold_valid", 64'(tx_valid), 64'd1);
            chk("tx_hold_data", 64'(tx_data), 64'(hold_data));
         end
         hold_prev = tx_valid && !tx_ready;
         hold_data = tx_data;
         if (!csb_n) begin
            if (!we_n) begin
               wr_cnt++;
               wr_addr_log.push_back(sram_addr);
               wr_data_log.push_back(sram_din);
               chk("write_expected", 64'(exp_wr.size() > 0), 64'd1);
               if (exp_wr.size() > 0) begin
                  logic [36:0] e;
                  e = exp_wr.pop_front();
                  chk("wr_addr", 64'(sram_addr), 64'(e[36:32]));
                  chk("wr_data", 64'(sram_din), 64'(e[31:0]));
               end
            end else begin
               rd_cnt++;
               chk("read_expected", 64'(exp_rd.size() > 0), 64'd1);
               if (exp_rd.size() > 0) chk("rd_addr", 64'(sram_addr), 64'(exp_rd.pop_front()));
            end
         end
         if (tx_valid && tx_ready) begin
            tx_cnt++;
            tx_log.push_back(tx_data);
            chk("tx_expected", 64'(exp_tx.size() > 0), 64'd1);
            if (exp_tx.size() > 0) chk("tx_byte", 64'(tx_data), 64'(exp_tx.pop_front()));
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      @(negedge clk);
      rx_data = b;
      rx_valid = 1'b1;
      t = 0;
      while (!rx_ready && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 1000) chk("rx_accept_timeout", 64'(t), 64'd0);
      @(posedge clk);
      #1 rx_valid = 1'b0;
      repeat (gap) @(posedge clk);
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      @(negedge clk);
      while (busy && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk("idle_reached", 64'(busy), 64'd0);
   endtask

   // Builds expectations from the command semantics, then drives the command.
   // For writes, the data words come from the `words` queue.
   task automatic do_cmd(input logic rd, input int len, input logic [4:0] addr,
                         input logic [2:0] junk, input int gap);
      logic [4:0] a;
      for (int i = 0; i < len; i++) begin
         a = 5'((int'(addr) + i) % 32);
         if (rd) begin
            exp_rd.push_back(a);
            for (int b = 0; b < 4; b++) exp_tx.push_back(ref_mem[a][8*b +: 8]);
         end else begin
            exp_wr.push_back({a, words[i]});
            ref_mem[a] = words[i];
         end
      end
`ifdef SRAM_BRIDGE_ACK_EN
      if (!rd) exp_tx.push_back({4'hA, 4'(len - 1)});
`endif
      send_byte({rd, junk, 4'(len - 1)}, gap);
      send_byte({3'b000, addr}, gap);
      if (!rd)
         for (int i = 0; i < len; i++)
            for (int b = 0; b < 4; b++) send_byte(words[i][8*b +: 8], (b == 1) ? gap + 2 : gap);
   endtask

   initial begin
      int base;
      int t;
      int wsave;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_csb_n", 64'(csb_n), 64'd1);
      chk("rst_we_n", 64'(we_n), 64'd1);
      chk("rst_rx_ready", 64'(rx_ready), 64'd0);
      chk("rst_tx_valid", 64'(tx_valid), 64'd0);
      chk("rst_tx_data", 64'(tx_data), 64'd0);
      chk("rst_sram_addr", 64'(sram_addr), 64'd0);
      chk("rst_sram_din", 64'(sram_din), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Single-word write to address 3
      words = {32'h44332211};
      do_cmd(1'b0, 1, 5'd3, 3'b000, 0);
      wait_idle();
      chk("lit_wr_addr", 64'(wr_addr_log[$]), 64'd3);
      chk("lit_wr_data", 64'(wr_data_log[$]), 64'h44332211);
      chk("lit_wr_count", 64'(wr_cnt), 64'd1);

      // Read it back: one access, bytes LSB first
      do_cmd(1'b1, 1, 5'd3, 3'b000, 0);
      wait_idle();
      chk("lit_rd_count", 64'(rd_cnt), 64'd1);
      chk("lit_tx_count", 64'(tx_log.size()), 64'd4);
      chk("lit_tx0", 64'(tx_log[0]), 64'h11);
      chk("lit_tx1", 64'(tx_log[1]), 64'h22);
      chk("lit_tx2", 64'(tx_log[2]), 64'h33);
      chk("lit_tx3", 64'(tx_log[3]), 64'h44);

      // Two-word write wrapping from 0x1F to 0x00, ignored header bits set, rx gaps
      words = {32'hDEADBEEF, 32'h01234567};
      do_cmd(1'b0, 2, 5'h1F, 3'b111, 1);
      wait_idle();
      chk("lit_wrap_a0", 64'(wr_addr_log[wr_addr_log.size()-2]), 64'h1F);
      chk("lit_wrap_a1", 64'(wr_addr_log[wr_addr_log.size()-1]), 64'h00);

      // Read the wrapped pair back, stalling tx for 10 cycles mid-word
      base = tx_cnt;
      do_cmd(1'b1, 2, 5'h1F, 3'b010, 0);
      t = 0;
      while (tx_cnt < base + 2 && t < 2000) begin
         @(posedge clk);
         t++;
      end
      chk("stall_start", 64'(tx_cnt >= base + 2), 64'd1);
      #1 tx_ready = 1'b0;
      repeat (10) @(posedge clk);
      #1 tx_ready = 1'b1;
      wait_idle();
      chk("stall_tx_total", 64'(tx_cnt - base), 64'd8);
      chk("lit_stall_b0", 64'(tx_log[base]), 64'hEF);
      chk("lit_stall_b4", 64'(tx_log[base+4]), 64'h67);

      // Reset pulse after 2 of 4 data bytes: no SRAM write may occur
      wsave = wr_cnt;
      send_byte(8'h00, 0);
      send_byte(8'h05, 0);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_csb_n", 64'(csb_n), 64'd1);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_rx_ready", 64'(rx_ready), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("mid_rst_no_write", 64'(wr_cnt), 64'(wsave));

      // Full commands after the abort; also four-word burst and an untouched address
      words = {32'hCAFEF00D};
      do_cmd(1'b0, 1, 5'd5, 3'b000, 0);
      wait_idle();
      do_cmd(1'b1, 1, 5'd5, 3'b000, 0);
      wait_idle();
      words = {32'h0A0B0C0D, 32'h10203040, 32'h55AA55AA, 32'hFFFF0000};
      do_cmd(1'b0, 4, 5'h10, 3'b000, 0);
      wait_idle();
      do_cmd(1'b1, 4, 5'h10, 3'b000, 0);
      wait_idle();
      do_cmd(1'b1, 1, 5'd9, 3'b000, 0);
      wait_idle();
      chk("lit_init_b0", 64'(tx_log[tx_log.size()-4]), 64'h09);
      chk("lit_init_b3", 64'(tx_log[tx_log.size()-1]), 64'hC9);

      repeat (5) @(negedge clk);
      chk("exp_wr_drained", 64'(exp_wr.size()), 64'd0);
      chk("exp_rd_drained", 64'(exp_rd.size()), 64'd0);
      chk("exp_tx_drained", 64'(exp_tx.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
